// File: rtl/regs_pkg.sv
// Shared constants and write-back payload for the RV32I integer register file.
package regs_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned REG_NUM = 32;
  localparam int unsigned CNT_W   = 32;

  localparam logic [DATA_W-1:0] ZERO_WORD = 32'h0;
  localparam logic [ADDR_W-1:0] ZERO_REG  = 5'h0;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wen;
  } wb_t;

  // A write only lands when enabled and not aimed at the hardwired x0.
  function automatic logic wb_accepted(input wb_t wb);
    return (wb.wen == WRITE_ENABLE) && (wb.addr != ZERO_REG);
  endfunction

endpackage

// File: rtl/regs_rd_mux.sv
// One read port: x0 forces zero, then same-cycle bypass (debug over core), then the array.
module regs_rd_mux
  import regs_pkg::*;
(
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic [DATA_W-1:0] arr_rdata_i,
  input  wb_t               core_wb_i,
  input  wb_t               dbg_wb_i,
  output logic [DATA_W-1:0] rdata_o
);

  always_comb begin
    rdata_o = arr_rdata_i;
    if (raddr_i == ZERO_REG) begin
      rdata_o = ZERO_WORD;
    end else if (dbg_wb_i.wen == WRITE_ENABLE && dbg_wb_i.addr == raddr_i) begin
      rdata_o = dbg_wb_i.data;
    end else if (core_wb_i.wen == WRITE_ENABLE && core_wb_i.addr == raddr_i) begin
      rdata_o = core_wb_i.data;
    end
  end

endmodule

// File: rtl/regs.sv
// RV32I integer register file with bypassed read ports and an accepted-write counter.
// Optional debug read/write port enabled by defining REGS_DEBUG_PORT_EN.
module regs
  import regs_pkg::*;
#(
  parameter int unsigned CNT_W = regs_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              rd_wen_i,
  input  logic [ADDR_W-1:0] reg1_raddr_i,
  input  logic [ADDR_W-1:0] reg2_raddr_i,
  output logic [DATA_W-1:0] reg1_rdata_o,
  output logic [DATA_W-1:0] reg2_rdata_o,
  output logic [CNT_W-1:0]  wr_cnt_o
`ifdef REGS_DEBUG_PORT_EN
  ,
  input  logic [ADDR_W-1:0] dbg_raddr_i,
  output logic [DATA_W-1:0] dbg_rdata_o,
  input  logic              dbg_wen_i,
  input  logic [ADDR_W-1:0] dbg_waddr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i
`endif
);

  logic [DATA_W-1:0] reg_q [REG_NUM];
  logic [DATA_W-1:0] reg_d [REG_NUM];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  wb_t               core_wb;
  wb_t               dbg_wb;
  logic              core_acc;
  logic              dbg_acc;

  assign core_wb = '{addr: rd_addr_i, data: rd_data_i, wen: rd_wen_i};

`ifdef REGS_DEBUG_PORT_EN
  assign dbg_wb = '{addr: dbg_waddr_i, data: dbg_wdata_i, wen: dbg_wen_i};
`else
  assign dbg_wb = '{addr: ZERO_REG, data: ZERO_WORD, wen: WRITE_DISABLE};
`endif

  assign core_acc = wb_accepted(core_wb);
  assign dbg_acc  = wb_accepted(dbg_wb);

  // Debug write is applied last so it wins an address collision.
  always_comb begin
    for (int i = 0; i < int'(REG_NUM); i++) begin
      reg_d[i] = reg_q[i];
    end
    cnt_d = cnt_q;
    if (core_acc) begin
      reg_d[core_wb.addr] = core_wb.data;
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (dbg_acc) begin
      reg_d[dbg_wb.addr] = dbg_wb.data;
    end
    reg_d[0] = ZERO_WORD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(REG_NUM); i++) begin
        reg_q[i] <= ZERO_WORD;
      end
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < int'(REG_NUM); i++) begin
        reg_q[i] <= reg_d[i];
      end
      cnt_q <= cnt_d;
    end
  end

  assign wr_cnt_o = cnt_q;

  regs_rd_mux u_rd_mux1 (
    .raddr_i     (reg1_raddr_i),
    .arr_rdata_i (reg_q[reg1_raddr_i]),
    .core_wb_i   (core_wb),
    .dbg_wb_i    (dbg_wb),
    .rdata_o     (reg1_rdata_o)
  );

  regs_rd_mux u_rd_mux2 (
    .raddr_i     (reg2_raddr_i),
    .arr_rdata_i (reg_q[reg2_raddr_i]),
    .core_wb_i   (core_wb),
    .dbg_wb_i    (dbg_wb),
    .rdata_o     (reg2_rdata_o)
  );

`ifdef REGS_DEBUG_PORT_EN
  regs_rd_mux u_rd_mux_dbg (
    .raddr_i     (dbg_raddr_i),
    .arr_rdata_i (reg_q[dbg_raddr_i]),
    .core_wb_i   (core_wb),
    .dbg_wb_i    (dbg_wb),
    .rdata_o     (dbg_rdata_o)
  );
`endif

endmodule

// File: doc/regs.md
Name: regs

Overview:
- Integer register file x0..x31 of the RV32I core.
- Write side: consumes the write-back triple produced by the execute stage (rd address, rd data, rd write enable).
- Read side: serves two combinational read ports to the decode stage, with same-cycle write-to-read bypass.
- Also keeps a retired-write counter for performance/debug visibility.

Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, register address width.
- REG_NUM, 32, number of architectural registers (2**ADDR_W).
- CNT_W, 32, width of the accepted-write counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rd_addr_i  input  ADDR_W  write address from execute stage.
- rd_data_i  input  DATA_W  write data from execute stage.
- rd_wen_i  input  1  write enable from execute stage.
- reg1_raddr_i  input  ADDR_W  read port 1 address from decode.
- reg2_raddr_i  input  ADDR_W  read port 2 address from decode.
- reg1_rdata_o  output  DATA_W  read port 1 data (combinational).
- reg2_rdata_o  output  DATA_W  read port 2 data (combinational).
- wr_cnt_o  output  CNT_W  count of accepted core writes (registered).

Behaviour:
- Reset:
  - While rst=1, all REG_NUM entries = 0 and wr_cnt_o = 0, asynchronously (no clock needed).
  - Writes presented on any edge while rst=1 are discarded.
  - Reset mid-stream loses all in-flight write data; the first write is accepted on the first rising edge with rst=0.
- Accepted write:
  - Defined as rd_wen_i=1 and rd_addr_i != 0 at a rising clk edge.
  - Entry rd_addr_i <= rd_data_i at that edge; latency 1 edge to the array.
- x0 handling:
  - x0 is hardwired to 0. Writes to address 0 are dropped and not counted.
  - Reads of address 0 return 0 regardless of bypass.
- Read mux, per port, priority order:
  1. raddr=0 -> 0.
  2. Else rd_wen_i=1 and rd_addr_i=raddr -> rd_data_i (same-cycle bypass, so decode sees the value the EX stage is retiring this cycle).
  3. Else the array entry.
  - Purely combinational, no read latency.
  - Both ports may address the same register; both return the same value.
- Counter:
  - wr_cnt_o increments by 1 on every accepted write.
  - Wraps from 2**CNT_W-1 to 0 silently.
- Other rules:
  - X on rd_addr_i while rd_wen_i=0 has no effect on state.
  - No stall input; upstream pipeline registers hold stable values during stalls and drop rd_wen_i.
- Simultaneous events: a write and a read of the same address in one cycle -> read returns the new data, and the array holds the new data after the edge.

Optional Feature:
- Macro: REGS_DEBUG_PORT_EN.
- When defined, adds these ports:
  - dbg_raddr_i in ADDR_W
  - dbg_rdata_o out DATA_W
  - dbg_wen_i in 1
  - dbg_waddr_i in ADDR_W
  - dbg_wdata_i in DATA_W
- Debug read uses the same combinational mux and bypass as the core ports.
- Debug write follows the same x0 rule as core writes.
- If the debug and core write hit the same address in one cycle, debug data wins both in the array and in all bypass paths.
- If they hit different addresses, both writes commit.
- Debug writes never increment wr_cnt_o.
- When not defined: none of these ports exist and behaviour is exactly as above.

Decomposition:
- Shared defines file holds:
  - ZERO_WORD (32'h0), ZERO_REG (5'h0).
  - REG_NUM, data width and address width constants.
  - Write-enable/disable constants, reused by execute and decode.
- One natural sub-module: regs_rd_mux.
  - Implements the x0/bypass/array priority for a single read port.
  - Instantiated twice, or three times with REGS_DEBUG_PORT_EN.

Test Plan:
- Reset check: assert rst mid-run with x5=32'hDEAD_BEEF -> reg1_rdata_o(x5)=0 immediately (before the next edge), and wr_cnt_o=0.
- Basic write/read: write x3=32'h1234_5678 at edge N, rd_wen_i=0 afterwards -> reg1 and reg2 reads of x3 return 32'h1234_5678 from N onward; wr_cnt_o=1.
- Bypass: with x7=0, drive rd_wen_i=1, rd_addr_i=7, rd_data_i=32'hA5A5_A5A5 and reg2_raddr_i=7 in the same cycle -> reg2_rdata_o=32'hA5A5_A5A5 before the edge.
- x0 handling: write x0=32'hFFFF_FFFF with reg1_raddr_i=0 -> reg1_rdata_o=0 before and after the edge; wr_cnt_o unchanged.
- Counter wrap: preload wr_cnt_o to 32'hFFFF_FFFF (force), then one write to x1 -> wr_cnt_o=0.
- Debug collision (REGS_DEBUG_PORT_EN): core writes x4=32'h1 and debug writes x4=32'h2 in the same cycle -> all ports read x4=32'h2 before and after the edge; wr_cnt_o increments by 1.
